seven_segment_mux: RTL and testbench

- Time-multiplexed driver for the 4-digit common-anode seven-segment display. Sits between user logic and the board pins.
- Scans digits 0..3 (digit 0 = rightmost) at a fixed refresh rate.
- Decodes each nibble through the existing seven_segment decoder and drives per-digit decimal points and blanking.
- Latches input data once per frame so displayed digits never tear, and inserts anode dead time between digits to suppress ghosting.

---
 rtl/seven_segment_pkg.sv | 18 +
 rtl/seven_segment.sv | 31 +++
 rtl/seven_segment_mux.sv | 107 ++++++++++
 tb/tb_seven_segment_mux.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/seven_segment_pkg.sv
// Shared constants and types for the multiplexed seven-segment display driver.
// Pins are active-low, so "all ones" turns a digit fully off.
package seven_segment_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [3:0] ANODE_OFF  = 4'b1111;
  localparam logic [7:0] SEG_BLANK  = 8'hFF;

  typedef logic [1:0] digit_sel_t;

  // One-cold anode pattern: only the selected digit's enable is pulled low.
  function automatic logic [3:0] anode_for(input digit_sel_t sel);
    logic [3:0] one_hot;
    one_hot = 4'b0001 << sel;
    return ~one_hot;
  endfunction

endpackage

// File: rtl/seven_segment.sv
// Hex nibble to seven-segment glyph decoder, active-low, segment[6:0] = g..a.
// Purely combinational; callers register the result.
module seven_segment (
  input  logic [3:0] data,
  output logic [6:0] segment
);

  always_comb begin
    segment = 7'b1111111;
    case (data)
      4'h0: segment = 7'b1000000;
      4'h1: segment = 7'b1111001;
      4'h2: segment = 7'b0100100;
      4'h3: segment = 7'b0110000;
      4'h4: segment = 7'b0011001;
      4'h5: segment = 7'b0010010;
      4'h6: segment = 7'b0000010;
      4'h7: segment = 7'b1111000;
      4'h8: segment = 7'b0000000;
      4'h9: segment = 7'b0010000;
      4'hA: segment = 7'b0001000;
      4'hB: segment = 7'b0000011;
      4'hC: segment = 7'b1000110;
      4'hD: segment = 7'b0100001;
      4'hE: segment = 7'b0000110;
      4'hF: segment = 7'b0001110;
      default: segment = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/seven_segment_mux.sv
// Time-multiplexed 4-digit common-anode display driver with per-frame input
// shadowing and anode dead time at the start of every digit slot.
module seven_segment_mux
  import seven_segment_pkg::*;
#(
  parameter int COUNT_BITS  = 17,
  parameter int DEAD_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_in,
  output logic [7:0]  segment,
  output logic [3:0]  anode,
  output logic        frame_tick
);

  localparam logic [COUNT_BITS-1:0] DEAD_CNT = COUNT_BITS'(DEAD_CYCLES);
  localparam digit_sel_t            LAST_DIGIT = digit_sel_t'(NUM_DIGITS - 1);

  logic [COUNT_BITS-1:0] cnt_q, cnt_d;
  digit_sel_t            digit_sel_q, digit_sel_d;
  logic [15:0]           data_shadow_q, data_shadow_d;
  logic [3:0]            dp_shadow_q, dp_shadow_d;
  logic [3:0]            blank_shadow_q, blank_shadow_d;
  logic [3:0]            anode_q, anode_d;
  logic [7:0]            segment_q, segment_d;
  logic                  frame_tick_q, frame_tick_d;

  logic                  cnt_wrap;
  logic                  frame_load;
  logic                  in_dead;
  logic [3:0]            nibble;
  logic [6:0]            glyph;
  logic [3:0]            nibbles [NUM_DIGITS];

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nibble
    assign nibbles[gi] = data_shadow_q[gi*4 +: 4];
  end

  assign nibble = nibbles[digit_sel_q];

  // Single decoder shared by all digits; only the active nibble is decoded.
  seven_segment u_decoder (
    .data    (nibble),
    .segment (glyph)
  );

  always_comb begin
    cnt_wrap       = &cnt_q;
    frame_load     = cnt_wrap && (digit_sel_q == LAST_DIGIT);
    in_dead        = cnt_q < DEAD_CNT;

    cnt_d          = cnt_q + COUNT_BITS'(1);
    digit_sel_d    = digit_sel_q;
    data_shadow_d  = data_shadow_q;
    dp_shadow_d    = dp_shadow_q;
    blank_shadow_d = blank_shadow_q;
    frame_tick_d   = frame_load;
    anode_d        = ANODE_OFF;
    segment_d      = SEG_BLANK;

    if (cnt_wrap) begin
      digit_sel_d = digit_sel_q + 2'd1;
    end

    // Inputs are captured only at the frame boundary so a frame never tears.
    if (frame_load) begin
      data_shadow_d  = data_in;
      dp_shadow_d    = dp_in;
      blank_shadow_d = blank_in;
    end

    if (!in_dead && !blank_shadow_q[digit_sel_q]) begin
      anode_d   = anode_for(digit_sel_q);
      segment_d = {~dp_shadow_q[digit_sel_q], glyph};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q          <= '0;
      digit_sel_q    <= '0;
      data_shadow_q  <= 16'h0000;
      dp_shadow_q    <= 4'b0000;
      blank_shadow_q <= 4'b0000;
      anode_q        <= ANODE_OFF;
      segment_q      <= SEG_BLANK;
      frame_tick_q   <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      digit_sel_q    <= digit_sel_d;
      data_shadow_q  <= data_shadow_d;
      dp_shadow_q    <= dp_shadow_d;
      blank_shadow_q <= blank_shadow_d;
      anode_q        <= anode_d;
      segment_q      <= segment_d;
      frame_tick_q   <= frame_tick_d;
    end
  end

  assign anode      = anode_q;
  assign segment    = segment_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_segment_mux.sv
// Scoreboard bench for seven_segment_mux with 8-clock slots and 1 dead cycle.
// Expected pin values per cycle are queued by the stimulus and popped by a monitor.
module tb_seven_segment_mux;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic [7:0]  segment;
  logic [3:0]  anode;
  logic        frame_tick;

  typedef struct {
    int          cyc;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        ft;
    string       name;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   cyc = 0;
  int   base = 0;
  int   checks = 0;
  int   errors = 0;
  bit   started = 1'b0;

  seven_segment_mux #(.COUNT_BITS(3), .DEAD_CYCLES(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .segment    (segment),
    .anode      (anode),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected pins for one frame; segs holds one byte per digit, digit 0 in [7:0].
  task automatic push_frame(input int f, input logic [31:0] segs,
                            input logic [3:0] blank, input int last_t);
    for (int d = 0; d < 4; d++) begin
      for (int k = 1; k <= 8; k++) begin
        int         t;
        exp_t       e;
        logic [3:0] one_hot;
        t = 32 * f + 8 * d + k;
        if (t <= last_t) begin
          one_hot = 4'b0001;
          one_hot = one_hot << d;
          e.cyc   = base + t;
          if (k == 1 || blank[d]) begin
            e.an  = 4'b1111;
            e.seg = 8'hFF;
          end else begin
            e.an  = ~one_hot;
            e.seg = segs[8*d +: 8];
          end
          e.ft   = (t % 32 == 0);
          e.name = $sformatf("frame%0d_digit%0d_t%0d", f, d, t);
          expq.push_back(e);
        end
      end
    end
  endtask

  // Pins must be all-off on the interval right after a sampled reset edge.
  task automatic push_reset_entry(input string name);
    exp_t e;
    e.cyc  = cyc + 1;
    e.an   = 4'b1111;
    e.seg  = 8'hFF;
    e.ft   = 1'b0;
    e.name = name;
    expq.push_back(e);
  endtask

  task automatic wait_t(input int t);
    while (cyc < base + t) @(negedge clk);
  endtask

  // Monitor: samples 1 time unit after every rising edge.
  always @(posedge clk) begin
    #1;
    if (started) begin
      checks++;
      if ($countones(~anode) > 1) begin
        errors++;
        $display("FAIL one_cold cyc=%0d: anode=%b has more than one low bit", cyc, anode);
      end
    end
    while (expq.size() > 0 && expq[0].cyc <= cyc) begin
      mon_e = expq.pop_front();
      checks++;
      if (mon_e.cyc != cyc || anode !== mon_e.an || segment !== mon_e.seg ||
          frame_tick !== mon_e.ft) begin
        errors++;
        $display("FAIL %s cyc=%0d: got anode=%b segment=%b frame_tick=%b, want anode=%b segment=%b frame_tick=%b (due cyc %0d)",
                 mon_e.name, cyc, anode, segment, frame_tick,
                 mon_e.an, mon_e.seg, mon_e.ft, mon_e.cyc);
      end
    end
  end

  initial begin
    int budget;
    reset    = 1'b1;
    data_in  = 16'h1234;
    dp_in    = 4'b0000;
    blank_in = 4'b0000;
    repeat (2) @(negedge clk);
    push_reset_entry("reset_state");
    @(negedge clk);
    reset   = 1'b0;
    base    = cyc;
    started = 1'b1;

    push_frame(0, 32'hC0C0C0C0, 4'b0000, 1000);   // shadows still zero: "0000"
    push_frame(1, 32'hF9A4B099, 4'b0000, 1000);   // "1234"
    push_frame(2, 32'hF9A4B099, 4'b0000, 1000);   // data change mid-frame not yet visible
    push_frame(3, 32'h8883C6A1, 4'b0000, 1000);   // "ABCD"
    push_frame(4, 32'hC040C0C0, 4'b0000, 1000);   // "0000" with DP on digit 2
    push_frame(5, 32'hF9A4B099, 4'b1010, 1000);   // digits 1 and 3 blanked
    push_frame(6, 32'hF9A4B099, 4'b1010, 212);    // cut short by reset in digit 2 slot

    wait_t(76);
    data_in = 16'hABCD;
    wait_t(100);
    data_in = 16'h0000;
    dp_in   = 4'b0100;
    wait_t(140);
    data_in  = 16'h1234;
    dp_in    = 4'b0000;
    blank_in = 4'b1010;
    wait_t(212);
    reset = 1'b1;
    push_reset_entry("mid_frame_reset");
    @(negedge clk);
    reset = 1'b0;
    base  = cyc;

    push_frame(0, 32'hC0C0C0C0, 4'b0000, 1000);   // shadows cleared by reset
    push_frame(1, 32'hF9A4B099, 4'b1010, 1000);

    budget = 0;
    while (expq.size() > 0 && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    if (expq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected entries never reached, want 0", expq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
